// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM pipeline stage: load/store opcodes,
// byte-enable patterns, FSM state encoding and opcode classification helpers.
package mem_stage_pkg;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  localparam logic [3:0] BE_BYTE    = 4'b0001;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_WORD    = 4'b1111;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;

  function automatic logic is_mem_op(input logic [5:0] op);
    case (op)
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_store_op(input logic [5:0] op);
    case (op)
      OP_SB, OP_SH, OP_SW: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [5:0] op, input logic [1:0] a);
    case (op)
      OP_LH, OP_LHU, OP_SH: return a[0];
      OP_LW, OP_SW:         return |a;
      default:              return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Load alignment: picks the addressed byte/halfword lane out of the bus read
// word and sign- or zero-extends it according to the load opcode.
//   i_op    load opcode
//   i_lane  effective address bits [1:0]
//   i_rdata raw bus read word
//   o_data  extended result for the MEM/WB register
module mem_stage_load_align
  import mem_stage_pkg::*;
(
  input  logic [5:0]  i_op,
  input  logic [1:0]  i_lane,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_rdata[{i_lane, 3'b000} +: 8];
    w_half = i_lane[1] ? i_rdata[31:16] : i_rdata[15:0];
    case (i_op)
      OP_LB:   o_data = {{24{w_byte[7]}}, w_byte};
      OP_LBU:  o_data = {24'h0, w_byte};
      OP_LH:   o_data = {{16{w_half[15]}}, w_half};
      OP_LHU:  o_data = {16'h0, w_half};
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: issues data-bus requests for loads/stores, stalls the
// upstream pipe while a request is outstanding, flags misaligned accesses and
// bus timeouts, and drives the MEM/WB register.
//   i_clk, i_a_rst_n          clock, async active-low reset
//   i_valid, i_instr_MemAc    EX/MEM instruction (opcode [31:26])
//   i_ALU_result_MemAc        effective address / ALU result
//   i_op2_MemAc               store data
//   o_stall                   freeze upstream pipe registers
//   o_mem_*/i_mem_*           data bus request / response
//   o_wb_*                    MEM/WB register
//   o_addr_err, o_bus_err     one-cycle error pulses
//
// state     | meaning
// ST_IDLE   | no request outstanding; non-memory ops pass through in 1 cycle
// ST_ACCESS | bus request held stable, waiting for ack or timeout
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic        i_clk,
  input  logic        i_a_rst_n,
  input  logic        i_valid,
  input  logic [31:0] i_instr_MemAc,
  input  logic [31:0] i_ALU_result_MemAc,
  input  logic [31:0] i_op2_MemAc,
  output logic        o_stall,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [3:0]  o_mem_be,
  output logic [31:0] o_mem_wdata,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rdata,
  output logic        o_wb_valid,
  output logic [31:0] o_wb_instr,
  output logic [31:0] o_wb_data,
  output logic        o_addr_err,
  output logic        o_bus_err
);

  localparam int CNT_W = ($clog2(ACK_TIMEOUT + 1) > 8) ? $clog2(ACK_TIMEOUT + 1) : 8;
  // Timeout fires on the non-ack cycle that would take the count to ACK_TIMEOUT.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_mem_req, r_mem_we;
  logic [31:0]      r_mem_addr, r_mem_wdata, r_ea, r_instr;
  logic [3:0]       r_mem_be;
  logic [5:0]       r_op;
  logic             r_wb_valid, r_addr_err, r_bus_err;
  logic [31:0]      r_wb_instr, r_wb_data;

  logic [5:0]  w_op;
  logic        w_mem, w_mis, w_start, w_timeout;
  logic [3:0]  w_be;
  logic [31:0] w_wdata, w_load_data;

  assign w_op      = i_instr_MemAc[31:26];
  assign w_mem     = is_mem_op(w_op);
  assign w_mis     = is_misaligned(w_op, i_ALU_result_MemAc[1:0]);
  assign w_start   = (r_state == ST_IDLE) & i_valid & w_mem & ~w_mis;
  assign w_timeout = (r_state == ST_ACCESS) & ~i_mem_ack & (r_cnt == CNT_LAST);

  // Stall drops on the timeout cycle so the upstream moves past the failed
  // op instead of replaying it; reset forces it low regardless of i_valid.
  assign o_stall = i_a_rst_n &
                   (w_start | ((r_state == ST_ACCESS) & ~i_mem_ack & ~w_timeout));

  always_comb begin
    w_be    = BE_WORD;
    w_wdata = i_op2_MemAc;
    case (w_op)
      OP_SB: begin
        w_be    = BE_BYTE << i_ALU_result_MemAc[1:0];
        w_wdata = {4{i_op2_MemAc[7:0]}};
      end
      OP_SH: begin
        w_be    = i_ALU_result_MemAc[1] ? BE_HALF_HI : BE_HALF_LO;
        w_wdata = {2{i_op2_MemAc[15:0]}};
      end
      default: ;
    endcase
  end

  mem_stage_load_align u_load_align (
    .i_op    (r_op),
    .i_lane  (r_ea[1:0]),
    .i_rdata (i_mem_rdata),
    .o_data  (w_load_data)
  );

  always_ff @(posedge i_clk or negedge i_a_rst_n) begin
    if (!i_a_rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_be    <= '0;
      r_mem_wdata <= '0;
      r_ea        <= '0;
      r_op        <= '0;
      r_instr     <= '0;
      r_wb_valid  <= 1'b0;
      r_wb_instr  <= '0;
      r_wb_data   <= '0;
      r_addr_err  <= 1'b0;
      r_bus_err   <= 1'b0;
    end else begin
      r_wb_valid <= 1'b0;
      r_addr_err <= 1'b0;
      r_bus_err  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_valid) begin
            if (w_mem) begin
              if (w_mis) begin
                r_addr_err <= 1'b1;
              end else begin
                r_state     <= ST_ACCESS;
                r_cnt       <= '0;
                r_mem_req   <= 1'b1;
                r_mem_we    <= is_store_op(w_op);
                r_mem_addr  <= {i_ALU_result_MemAc[31:2], 2'b00};
                r_mem_be    <= w_be;
                r_mem_wdata <= w_wdata;
                r_ea        <= i_ALU_result_MemAc;
                r_op        <= w_op;
                r_instr     <= i_instr_MemAc;
              end
            end else begin
              r_wb_valid <= 1'b1;
              r_wb_instr <= i_instr_MemAc;
              r_wb_data  <= i_ALU_result_MemAc;
            end
          end
        end
        ST_ACCESS: begin
          if (i_mem_ack) begin
            r_state    <= ST_IDLE;
            r_mem_req  <= 1'b0;
            r_mem_we   <= 1'b0;
            r_wb_valid <= 1'b1;
            r_wb_instr <= r_instr;
            r_wb_data  <= r_mem_we ? r_ea : w_load_data;
          end else if (w_timeout) begin
            r_state   <= ST_IDLE;
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            r_bus_err <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_mem_req   = r_mem_req;
  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_be    = r_mem_be;
  assign o_mem_wdata = r_mem_wdata;
  assign o_wb_valid  = r_wb_valid;
  assign o_wb_instr  = r_wb_instr;
  assign o_wb_data   = r_wb_data;
  assign o_addr_err  = r_addr_err;
  assign o_bus_err   = r_bus_err;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: table of load/store/ALU vectors with a bus responder,
// a MEM/WB scoreboard, and directed timeout / idle-ack / reset sequences.
module tb_mem_stage;

  logic        i_clk = 1'b0;
  logic        i_a_rst_n;
  logic        i_valid;
  logic [31:0] i_instr_MemAc, i_ALU_result_MemAc, i_op2_MemAc;
  logic        o_stall, o_mem_req, o_mem_we;
  logic [31:0] o_mem_addr, o_mem_wdata;
  logic [3:0]  o_mem_be;
  logic        i_mem_ack;
  logic [31:0] i_mem_rdata;
  logic        o_wb_valid;
  logic [31:0] o_wb_instr, o_wb_data;
  logic        o_addr_err, o_bus_err;

  always #5 i_clk = ~i_clk;

  mem_stage #(.ACK_TIMEOUT(4)) dut (
    .i_clk              (i_clk),
    .i_a_rst_n          (i_a_rst_n),
    .i_valid            (i_valid),
    .i_instr_MemAc      (i_instr_MemAc),
    .i_ALU_result_MemAc (i_ALU_result_MemAc),
    .i_op2_MemAc        (i_op2_MemAc),
    .o_stall            (o_stall),
    .o_mem_req          (o_mem_req),
    .o_mem_we           (o_mem_we),
    .o_mem_addr         (o_mem_addr),
    .o_mem_be           (o_mem_be),
    .o_mem_wdata        (o_mem_wdata),
    .i_mem_ack          (i_mem_ack),
    .i_mem_rdata        (i_mem_rdata),
    .o_wb_valid         (o_wb_valid),
    .o_wb_instr         (o_wb_instr),
    .o_wb_data          (o_wb_data),
    .o_addr_err         (o_addr_err),
    .o_bus_err          (o_bus_err)
  );

  // kind: 0 = non-memory, 1 = aligned memory op, 2 = misaligned
  typedef struct {
    logic [5:0]  op;
    logic [31:0] alu;
    logic [31:0] op2;
    logic [31:0] rdata;
    int          delay;
    int          kind;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] wb;
  } vec_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] data;
  } exp_t;

  int   checks = 0;
  int   failures = 0;
  int   n_bus_err = 0;
  int   n_addr_err = 0;
  exp_t sb_q[$];
  vec_t vecs[15];
  logic [31:0] last_instr, last_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [5:0] op, input logic [31:0] alu, input logic [31:0] op2,
                              input logic [31:0] rdata, input int delay, input int kind,
                              input logic we, input logic [3:0] be, input logic [31:0] wdata,
                              input logic [31:0] wb);
    vec_t v;
    v.op = op; v.alu = alu; v.op2 = op2; v.rdata = rdata; v.delay = delay;
    v.kind = kind; v.we = we; v.be = be; v.wdata = wdata; v.wb = wb;
    return v;
  endfunction

  // Called at posedge+1; returns at a later posedge+1 with i_valid low.
  task automatic apply_vec(input vec_t v, input int idx);
    logic [31:0] instr;
    int n_stall;
    exp_t e;
    instr = {v.op, 10'h0, 16'(idx)};
    i_valid = 1'b1;
    i_instr_MemAc = instr;
    i_ALU_result_MemAc = v.alu;
    i_op2_MemAc = v.op2;
    if (v.kind != 2) begin
      e.instr = instr; e.data = v.wb;
      sb_q.push_back(e);
      last_instr = instr; last_data = v.wb;
    end
    #1;
    chk($sformatf("v%0d_stall_issue", idx), o_stall, (v.kind == 1) ? 1 : 0);
    if (v.kind == 1) begin
      @(posedge i_clk); #1;
      chk($sformatf("v%0d_req", idx), o_mem_req, 1);
      chk($sformatf("v%0d_addr", idx), o_mem_addr, {v.alu[31:2], 2'b00});
      chk($sformatf("v%0d_be", idx), o_mem_be, v.be);
      chk($sformatf("v%0d_we", idx), o_mem_we, v.we);
      if (v.we) chk($sformatf("v%0d_wdata", idx), o_mem_wdata, v.wdata);
      n_stall = 1;
      for (int k = 0; k < v.delay; k++) begin
        chk($sformatf("v%0d_stall_wait%0d", idx, k), o_stall, 1);
        n_stall++;
        @(posedge i_clk); #1;
        chk($sformatf("v%0d_addr_hold%0d", idx, k), o_mem_addr, {v.alu[31:2], 2'b00});
      end
      i_mem_ack = 1'b1;
      i_mem_rdata = v.rdata;
      #1;
      chk($sformatf("v%0d_stall_ack", idx), o_stall, 0);
      chk($sformatf("v%0d_stall_cycles", idx), n_stall, v.delay + 1);
      @(posedge i_clk); #1;
      i_mem_ack = 1'b0;
      chk($sformatf("v%0d_wb_valid", idx), o_wb_valid, 1);
      chk($sformatf("v%0d_req_drop", idx), o_mem_req, 0);
      chk($sformatf("v%0d_bus_err", idx), o_bus_err, 0);
    end else begin
      @(posedge i_clk); #1;
      chk($sformatf("v%0d_wb_valid", idx), o_wb_valid, (v.kind == 0) ? 1 : 0);
      chk($sformatf("v%0d_addr_err", idx), o_addr_err, (v.kind == 2) ? 1 : 0);
      chk($sformatf("v%0d_no_req", idx), o_mem_req, 0);
    end
    i_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    i_a_rst_n = 1'b0; i_valid = 1'b0; i_instr_MemAc = '0; i_ALU_result_MemAc = '0;
    i_op2_MemAc = '0; i_mem_ack = 1'b0; i_mem_rdata = '0;
    last_instr = '0; last_data = '0;

    fork
      forever begin
        @(negedge i_clk);
        if (o_bus_err) n_bus_err++;
        if (o_addr_err) n_addr_err++;
        if (o_wb_valid) begin
          if (sb_q.size() == 0) begin
            chk("wb_unexpected", o_wb_instr, 32'h0);
            if (o_wb_instr == 32'h0) begin
              failures++;
              $display("FAIL wb_unexpected actual=valid required=idle");
            end
          end else begin
            exp_t e;
            e = sb_q.pop_front();
            chk("sb_instr", o_wb_instr, e.instr);
            chk("sb_data", o_wb_data, e.data);
          end
        end
      end
    join_none

    vecs[0]  = mk(6'h23, 32'h100, 32'h0, 32'hDEADBEEF, 3, 1, 1'b0, 4'hF, 32'h0, 32'hDEADBEEF);
    vecs[1]  = mk(6'h20, 32'h103, 32'h0, 32'h80FF0011, 0, 1, 1'b0, 4'hF, 32'h0, 32'hFFFFFF80);
    vecs[2]  = mk(6'h24, 32'h103, 32'h0, 32'h80FF0011, 1, 1, 1'b0, 4'hF, 32'h0, 32'h00000080);
    vecs[3]  = mk(6'h25, 32'h102, 32'h0, 32'h80FF0011, 2, 1, 1'b0, 4'hF, 32'h0, 32'h000080FF);
    vecs[4]  = mk(6'h21, 32'h102, 32'h0, 32'h80FF0011, 0, 1, 1'b0, 4'hF, 32'h0, 32'hFFFF80FF);
    vecs[5]  = mk(6'h21, 32'h100, 32'h0, 32'h00117FFF, 1, 1, 1'b0, 4'hF, 32'h0, 32'h00007FFF);
    vecs[6]  = mk(6'h29, 32'h202, 32'h1234ABCD, 32'h0, 1, 1, 1'b1, 4'b1100, 32'hABCDABCD, 32'h202);
    vecs[7]  = mk(6'h28, 32'h301, 32'h000000A5, 32'h0, 0, 1, 1'b1, 4'b0010, 32'hA5A5A5A5, 32'h301);
    vecs[8]  = mk(6'h2B, 32'h400, 32'hCAFEF00D, 32'h0, 2, 1, 1'b1, 4'hF, 32'hCAFEF00D, 32'h400);
    vecs[9]  = mk(6'h23, 32'h101, 32'h0, 32'h0, 0, 2, 1'b0, 4'h0, 32'h0, 32'h0);
    vecs[10] = mk(6'h21, 32'h103, 32'h0, 32'h0, 0, 2, 1'b0, 4'h0, 32'h0, 32'h0);
    vecs[11] = mk(6'h2B, 32'h402, 32'h0, 32'h0, 0, 2, 1'b0, 4'h0, 32'h0, 32'h0);
    vecs[12] = mk(6'h00, 32'h12345678, 32'h0, 32'h0, 0, 0, 1'b0, 4'h0, 32'h0, 32'h12345678);
    vecs[13] = mk(6'h20, 32'h100, 32'h0, 32'h7F0000FE, 3, 1, 1'b0, 4'hF, 32'h0, 32'hFFFFFFFE);
    vecs[14] = mk(6'h22, 32'h3, 32'h0, 32'h0, 0, 0, 1'b0, 4'h0, 32'h0, 32'h3);

    #3;
    chk("rst_req", o_mem_req, 0);
    chk("rst_stall", o_stall, 0);
    chk("rst_wb_valid", o_wb_valid, 0);
    chk("rst_wb_data", o_wb_data, 0);
    chk("rst_errs", {o_addr_err, o_bus_err}, 0);
    #20 i_a_rst_n = 1'b1;

    @(posedge i_clk); #1;
    for (int i = 0; i < 15; i++) apply_vec(vecs[i], i);

    // idle cycle: MEM/WB holds its last values
    @(posedge i_clk); #1;
    chk("idle_wb_valid", o_wb_valid, 0);
    chk("idle_wb_instr_hold", o_wb_instr, last_instr);
    chk("idle_wb_data_hold", o_wb_data, last_data);

    // ack while idle is ignored
    i_mem_ack = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(posedge i_clk); #1;
      chk("idle_ack_req", o_mem_req, 0);
      chk("idle_ack_wb", o_wb_valid, 0);
    end
    i_mem_ack = 1'b0;

    // timeout: no ack for 4 ACCESS cycles
    i_valid = 1'b1; i_instr_MemAc = {6'h23, 26'h55}; i_ALU_result_MemAc = 32'h500;
    @(posedge i_clk); #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("to_req%0d", k), o_mem_req, 1);
      chk($sformatf("to_stall%0d", k), o_stall, 1);
      @(posedge i_clk); #1;
    end
    chk("to_req_last", o_mem_req, 1);
    chk("to_stall_release", o_stall, 0);
    chk("to_no_err_yet", o_bus_err, 0);
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    chk("to_bus_err", o_bus_err, 1);
    chk("to_req_drop", o_mem_req, 0);
    chk("to_wb_valid", o_wb_valid, 0);
    #1 chk("to_stall_idle", o_stall, 0);
    @(posedge i_clk); #1;
    chk("to_bus_err_pulse", o_bus_err, 0);

    // reset in the middle of an access
    i_valid = 1'b1; i_instr_MemAc = {6'h23, 26'h66}; i_ALU_result_MemAc = 32'h600;
    @(posedge i_clk); #1;
    chk("mr_req_before", o_mem_req, 1);
    @(posedge i_clk); #1;
    i_a_rst_n = 1'b0;
    #1;
    chk("mr_req", o_mem_req, 0);
    chk("mr_stall", o_stall, 0);
    chk("mr_be", o_mem_be, 0);
    chk("mr_wb_valid", o_wb_valid, 0);
    i_valid = 1'b0;
    @(negedge i_clk);
    i_a_rst_n = 1'b1;
    @(posedge i_clk); #1;
    chk("mr_post_req", o_mem_req, 0);
    chk("mr_post_wb", o_wb_valid, 0);
    apply_vec(mk(6'h00, 32'h0BADF00D, 32'h0, 32'h0, 0, 0, 1'b0, 4'h0, 32'h0, 32'h0BADF00D), 99);

    for (int k = 0; k < 5 && sb_q.size() != 0; k++) @(posedge i_clk);
    @(posedge i_clk); #1;
    chk("sb_drained", sb_q.size(), 0);
    chk("bus_err_pulses", n_bus_err, 1);
    chk("addr_err_pulses", n_addr_err, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
